// File: rtl/wall_placer.sv
// Wall-position writer: LFSR-driven placement of four non-overlapping walls, staged in shadow
// registers and committed together on a frame_clk rising edge. Optional keep-out box: WALL_PLACER_KEEPOUT_EN.
module wall_placer #(
  parameter logic [9:0] X_Max     = 10'd639,
  parameter logic [9:0] Y_Max     = 10'd479,
  parameter logic [9:0] Hor_W     = 10'd64,
  parameter logic [9:0] Hor_H     = 10'd32,
  parameter logic [9:0] Vert_W    = 10'd32,
  parameter logic [9:0] Vert_H    = 10'd64,
  parameter logic [9:0] MARGIN    = 10'd8,
  parameter logic [7:0] MAX_TRIES = 8'd64
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       place_req,
  input  logic [9:0] seed,
  input  logic [9:0] keep_x,
  input  logic [9:0] keep_y,
  input  logic [9:0] keep_w,
  input  logic [9:0] keep_h,
  output logic [9:0] X1,
  output logic [9:0] Y1,
  output logic [9:0] X2,
  output logic [9:0] Y2,
  output logic [9:0] X3,
  output logic [9:0] Y3,
  output logic [9:0] X4,
  output logic [9:0] Y4,
  output logic       busy,
  output logic       done,
  output logic       fallback
);

  localparam logic [15:0] LFSR_INIT = 16'hACE1;
  localparam logic [9:0]  DEF_X [4] = '{10'd50, 10'd400, 10'd320, 10'd600};
  localparam logic [9:0]  DEF_Y [4] = '{10'd100, 10'd200, 10'd240, 10'd400};

  typedef enum logic [2:0] {
    IDLE, GEN, CHECK, ACCEPT, REJECT, WAIT_FRAME, COMMIT
  } state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [1:0]  k;
  logic [1:0]  j;
  logic [7:0]  tries;
  logic        fb_pending;
  logic [9:0]  cand_x;
  logic [9:0]  cand_y;
  logic [9:0]  sx [4];
  logic [9:0]  sy [4];
  logic [2:0]  fsync;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Even-indexed walls are horizontal, odd-indexed vertical.
  function automatic logic [9:0] wall_w(input logic [1:0] idx);
    return idx[0] ? Vert_W : Hor_W;
  endfunction

  function automatic logic [9:0] wall_h(input logic [1:0] idx);
    return idx[0] ? Vert_H : Hor_H;
  endfunction

  // Inclusive-extent overlap with MARGIN padding; 12-bit sums so nothing wraps.
  function automatic logic boxes_meet(
    input logic [9:0] ax, input logic [9:0] ay, input logic [9:0] aw, input logic [9:0] ah,
    input logic [9:0] bx, input logic [9:0] by, input logic [9:0] bw, input logic [9:0] bh
  );
    logic x_hit, y_hit;
    x_hit = ({2'b0, ax} <= {2'b0, bx} + {2'b0, bw} + {2'b0, MARGIN}) &&
            ({2'b0, bx} <= {2'b0, ax} + {2'b0, aw} + {2'b0, MARGIN});
    y_hit = ({2'b0, ay} <= {2'b0, by} + {2'b0, bh} + {2'b0, MARGIN}) &&
            ({2'b0, by} <= {2'b0, ay} + {2'b0, ah} + {2'b0, MARGIN});
    return x_hit && y_hit;
  endfunction

  logic [15:0] lfsr_nxt;
  logic [9:0]  gen_x;
  logic [9:0]  gen_y;
  logic        in_bounds;
  logic        keep_hit;
  logic        gen_ok;
  logic        check_hit;
  logic        frame_rise;

  assign lfsr_nxt   = lfsr_step(lfsr);
  assign gen_x      = lfsr_nxt[9:0];
  assign gen_y      = lfsr_nxt[15:6];
  assign in_bounds  = (({1'b0, gen_x} + {1'b0, wall_w(k)}) <= {1'b0, X_Max}) &&
                      (({1'b0, gen_y} + {1'b0, wall_h(k)}) <= {1'b0, Y_Max});
  assign gen_ok     = in_bounds && !keep_hit;
  assign check_hit  = boxes_meet(cand_x, cand_y, wall_w(k), wall_h(k),
                                 sx[j], sy[j], wall_w(j), wall_h(j));
  assign frame_rise = fsync[1] && !fsync[2];

`ifdef WALL_PLACER_KEEPOUT_EN
  logic [9:0] kx_r, ky_r, kw_r, kh_r;

  // Keep-out box is captured with the request so it stays stable for the whole search.
  always_ff @(posedge Clk) begin
    if (state == IDLE && place_req) begin
      kx_r <= keep_x;
      ky_r <= keep_y;
      kw_r <= keep_w;
      kh_r <= keep_h;
    end
  end

  assign keep_hit = boxes_meet(gen_x, gen_y, wall_w(k), wall_h(k), kx_r, ky_r, kw_r, kh_r);
`else
  logic keep_unused;
  assign keep_unused = ^{keep_x, keep_y, keep_w, keep_h};
  assign keep_hit    = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      lfsr       <= LFSR_INIT;
      k          <= 2'd0;
      j          <= 2'd0;
      tries      <= 8'd0;
      fb_pending <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fallback   <= 1'b0;
      cand_x     <= 10'd0;
      cand_y     <= 10'd0;
      fsync      <= 3'b000;
      for (int i = 0; i < 4; i++) begin
        sx[i] <= DEF_X[i];
        sy[i] <= DEF_Y[i];
      end
      X1 <= DEF_X[0]; Y1 <= DEF_Y[0];
      X2 <= DEF_X[1]; Y2 <= DEF_Y[1];
      X3 <= DEF_X[2]; Y3 <= DEF_Y[2];
      X4 <= DEF_X[3]; Y4 <= DEF_Y[3];
    end else begin
      fsync <= {fsync[1:0], frame_clk};
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (place_req) begin
            lfsr       <= ((lfsr ^ {6'b0, seed}) == 16'd0) ? LFSR_INIT : (lfsr ^ {6'b0, seed});
            k          <= 2'd0;
            tries      <= 8'd0;
            fb_pending <= 1'b0;
            busy       <= 1'b1;
            state      <= GEN;
          end
        end
        GEN: begin
          lfsr   <= lfsr_nxt;
          cand_x <= gen_x;
          cand_y <= gen_y;
          tries  <= tries + 8'd1;
          j      <= 2'd0;
          if (!gen_ok)         state <= REJECT;
          else if (k == 2'd0)  state <= ACCEPT;
          else                 state <= CHECK;
        end
        CHECK: begin
          if (check_hit)                state <= REJECT;
          else if ((j + 2'd1) == k)     state <= ACCEPT;
          else                          j     <= j + 2'd1;
        end
        ACCEPT: begin
          sx[k] <= cand_x;
          sy[k] <= cand_y;
          tries <= 8'd0;
          if (k == 2'd3) begin
            state <= WAIT_FRAME;
          end else begin
            k     <= k + 2'd1;
            state <= GEN;
          end
        end
        REJECT: begin
          // Give up on this layout entirely: walls already accepted are discarded too.
          if (tries == MAX_TRIES) begin
            for (int i = 0; i < 4; i++) begin
              sx[i] <= DEF_X[i];
              sy[i] <= DEF_Y[i];
            end
            fb_pending <= 1'b1;
            state      <= WAIT_FRAME;
          end else begin
            state <= GEN;
          end
        end
        WAIT_FRAME: begin
          if (frame_rise) begin
            X1 <= sx[0]; Y1 <= sy[0];
            X2 <= sx[1]; Y2 <= sy[1];
            X3 <= sx[2]; Y3 <= sy[2];
            X4 <= sx[3]; Y4 <= sy[3];
            fallback <= fb_pending;
            done     <= 1'b1;
            state    <= COMMIT;
          end
        end
        COMMIT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wall_placer.sv
// Directed/table-driven bench for wall_placer with a behavioural placement model.
`timescale 1ns/1ps
module tb_wall_placer;

  localparam logic [79:0] DEF_LAY = {10'd50, 10'd100, 10'd400, 10'd200,
                                     10'd320, 10'd240, 10'd600, 10'd400};

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_n, frame_clk, place_req, place_req_s;
  logic [9:0] seed, keep_x, keep_y, keep_w, keep_h;
  logic [9:0] x1, y1, x2, y2, x3, y3, x4, y4;
  logic [9:0] x1s, y1s, x2s, y2s, x3s, y3s, x4s, y4s;
  logic       busy, done, fallback, busy_s, done_s, fallback_s;
  logic [79:0] lay, lay_s;

  assign lay   = {x1, y1, x2, y2, x3, y3, x4, y4};
  assign lay_s = {x1s, y1s, x2s, y2s, x3s, y3s, x4s, y4s};

  wall_placer u_dut (
    .Clk(clk), .Reset_n(rst_n), .frame_clk(frame_clk), .place_req(place_req), .seed(seed),
    .keep_x(keep_x), .keep_y(keep_y), .keep_w(keep_w), .keep_h(keep_h),
    .X1(x1), .Y1(y1), .X2(x2), .Y2(y2), .X3(x3), .Y3(y3), .X4(x4), .Y4(y4),
    .busy(busy), .done(done), .fallback(fallback)
  );

  wall_placer #(.X_Max(10'd60)) u_small (
    .Clk(clk), .Reset_n(rst_n), .frame_clk(frame_clk), .place_req(place_req_s), .seed(seed),
    .keep_x(keep_x), .keep_y(keep_y), .keep_w(keep_w), .keep_h(keep_h),
    .X1(x1s), .Y1(y1s), .X2(x2s), .Y2(y2s), .X3(x3s), .Y3(y3s), .X4(x4s), .Y4(y4s),
    .busy(busy_s), .done(done_s), .fallback(fallback_s)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model of the placement search
  logic [15:0] m_lfsr;

  function automatic bit m_hit(input int ax, ay, aw, ah, bx, by, bw, bh);
    return (ax <= bx + bw + 8) && (bx <= ax + aw + 8) &&
           (ay <= by + bh + 8) && (by <= ay + ah + 8);
  endfunction

  function automatic void model_run(input logic [9:0] s, input logic [9:0] kx, ky, kw, kh,
                                    output logic [79:0] l, output logic fb);
    int px[4], py[4];
    int k, tries, cx, cy, cw, ch;
    bit ok;
    m_lfsr = m_lfsr ^ {6'b0, s};
    if (m_lfsr == 16'd0) m_lfsr = 16'hACE1;
    k = 0; tries = 0; fb = 1'b0;
    while (k < 4 && !fb) begin
      m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
      cx = int'(m_lfsr[9:0]);
      cy = int'(m_lfsr[15:6]);
      cw = (k % 2 == 0) ? 64 : 32;
      ch = (k % 2 == 0) ? 32 : 64;
      tries++;
      ok = (cx + cw <= 639) && (cy + ch <= 479);
`ifdef WALL_PLACER_KEEPOUT_EN
      if (ok && m_hit(cx, cy, cw, ch, int'(kx), int'(ky), int'(kw), int'(kh))) ok = 0;
`endif
      for (int q = 0; q < k; q++)
        if (ok && m_hit(cx, cy, cw, ch, px[q], py[q], (q % 2 == 0) ? 64 : 32, (q % 2 == 0) ? 32 : 64))
          ok = 0;
      if (ok) begin
        px[k] = cx; py[k] = cy; k++; tries = 0;
      end else if (tries == 64) begin
        fb = 1'b1;
      end
    end
    if (fb) l = DEF_LAY;
    else    l = {px[0][9:0], py[0][9:0], px[1][9:0], py[1][9:0],
                 px[2][9:0], py[2][9:0], px[3][9:0], py[3][9:0]};
  endfunction

  function automatic bit valid_layout(input logic [79:0] l);
    int px[4], py[4], pw[4], ph[4];
    bit ok = 1;
    for (int q = 0; q < 4; q++) begin
      px[q] = int'(l[79 - 20*q -: 10]);
      py[q] = int'(l[69 - 20*q -: 10]);
      pw[q] = (q % 2 == 0) ? 64 : 32;
      ph[q] = (q % 2 == 0) ? 32 : 64;
      if (px[q] + pw[q] > 639 || py[q] + ph[q] > 479) ok = 0;
    end
    for (int a = 0; a < 4; a++)
      for (int b = a + 1; b < 4; b++)
        if (m_hit(px[a], py[a], pw[a], ph[a], px[b], py[b], pw[b], ph[b])) ok = 0;
    return ok;
  endfunction

  // One request on u_dut: hold>0 keeps frame_clk low that many cycles then raises it.
  task automatic run_req(input logic [9:0] s, input logic [9:0] kx, ky, kw, kh,
                         input logic [79:0] exp_lay, input logic exp_fb,
                         input int hold, input bit extra, input string tag);
    logic [79:0] prev;
    bit held, got, quiet;
    int n, rise_n;
    prev = lay; held = 1; got = 0; quiet = 1; n = 0; rise_n = 0;
    keep_x = kx; keep_y = ky; keep_w = kw; keep_h = kh; seed = s;
    frame_clk = 1'b0;
    place_req = 1'b1;
    @(negedge clk);
    place_req = 1'b0;
    chk($sformatf("%s_busy_rise", tag), busy, 1);
    while (!got && n < 4000) begin
      @(negedge clk);
      n++;
      place_req = extra && (n == 3);
      if (done === 1'b1) got = 1;
      else if (lay !== prev || busy !== 1'b1) held = 0;
      if (!got) begin
        if (hold > 0) begin
          if (n == hold) begin frame_clk = 1'b1; rise_n = n; end
        end else begin
          frame_clk = ((n >> 2) & 1) != 0;
        end
      end
    end
    chk($sformatf("%s_done_seen", tag), got, 1);
    chk($sformatf("%s_held", tag), held, 1);
    chk($sformatf("%s_layout", tag), lay, exp_lay);
    chk($sformatf("%s_fallback", tag), fallback, exp_fb);
    chk($sformatf("%s_busy_at_done", tag), busy, 1);
    if (hold > 0) chk($sformatf("%s_latency_ok", tag), (n - rise_n >= 1) && (n - rise_n <= 4), 1);
    place_req = extra;
    @(negedge clk);
    place_req = 1'b0;
    chk($sformatf("%s_busy_fall", tag), {busy, done}, 2'b00);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      frame_clk = ((c >> 1) & 1) != 0;
      if (busy !== 1'b0 || done !== 1'b0) quiet = 0;
    end
    chk($sformatf("%s_single_done", tag), quiet, 1);
    frame_clk = 1'b0;
  endtask

  typedef struct {
    logic [9:0]  seed, kx, ky, kw, kh;
    logic [79:0] lay;
    logic        fb;
  } vec_t;

  function automatic vec_t mk(input logic [9:0] s, kx, ky, kw, kh);
    vec_t v;
    v.seed = s; v.kx = kx; v.ky = ky; v.kw = kw; v.kh = kh;
    model_run(s, kx, ky, kw, kh, v.lay, v.fb);
    return v;
  endfunction

  vec_t vecs [6];

  initial begin
    logic [79:0] el;
    logic        ef;
    logic [9:0]  rs;
    int n, dcount;
    bit quiet;

    rst_n = 1'b0; frame_clk = 1'b0; place_req = 1'b0; place_req_s = 1'b0;
    seed = '0; keep_x = '0; keep_y = '0; keep_w = '0; keep_h = '0;
    m_lfsr = 16'hACE1;

    repeat (3) @(negedge clk);
    chk("rst_low_layout", lay, DEF_LAY);
    chk("rst_low_flags", {busy, done, fallback}, 3'b000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rel_layout", lay, DEF_LAY);
    chk("rst_rel_flags", {busy, done, fallback}, 3'b000);
    chk("rst_small_layout", lay_s, DEF_LAY);

    model_run(10'h155, '0, '0, '0, '0, el, ef);
    run_req(10'h155, '0, '0, '0, '0, el, ef, 1500, 0, "hold155");

    vecs[0] = mk(10'h3FF, '0, '0, '0, '0);
    vecs[1] = mk(10'h000, '0, '0, '0, '0);
    vecs[2] = mk(10'h02A, '0, '0, '0, '0);
    vecs[3] = mk(10'h1C3, '0, '0, '0, '0);
    vecs[4] = mk(10'h001, 10'd0, 10'd0, 10'd639, 10'd479);
    vecs[5] = mk(10'h0FF, 10'd100, 10'd100, 10'd50, 10'd50);
    for (int i = 0; i < 6; i++)
      run_req(vecs[i].seed, vecs[i].kx, vecs[i].ky, vecs[i].kw, vecs[i].kh,
              vecs[i].lay, vecs[i].fb, 0, (i == 1), $sformatf("vec%0d", i));

    for (int r = 0; r < 200; r++) begin
      rs = 10'($urandom_range(0, 1023));
      model_run(rs, '0, '0, '0, '0, el, ef);
      run_req(rs, '0, '0, '0, '0, el, ef, 0, 0, $sformatf("rnd%0d", r));
      if (!ef) chk($sformatf("rnd%0d_valid", r), valid_layout(lay), 1);
    end

    // Narrow X_Max: no candidate can fit, search must fall back
    place_req_s = 1'b1;
    @(negedge clk);
    place_req_s = 1'b0;
    n = 0; dcount = 0;
    while (dcount == 0 && n < 4000) begin
      @(negedge clk);
      n++;
      if (done_s === 1'b1) dcount++;
      frame_clk = ((n >> 2) & 1) != 0;
    end
    chk("small_fallback", fallback_s, 1);
    chk("small_layout", lay_s, DEF_LAY);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      frame_clk = ((c >> 2) & 1) != 0;
      if (done_s === 1'b1) dcount++;
    end
    chk("small_done_once", dcount, 1);
    chk("small_busy_clear", busy_s, 0);
    frame_clk = 1'b0;

    // Reset mid-search
    seed = 10'h0AA;
    place_req = 1'b1;
    @(negedge clk);
    place_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_layout", lay, DEF_LAY);
    chk("midrst_flags", {busy, done, fallback}, 3'b000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_lfsr = 16'hACE1;
    quiet = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      frame_clk = ((c >> 2) & 1) != 0;
      if (busy !== 1'b0 || done !== 1'b0) quiet = 0;
    end
    frame_clk = 1'b0;
    chk("midrst_no_done", quiet, 1);
    model_run(10'h0AA, '0, '0, '0, '0, el, ef);
    run_req(10'h0AA, '0, '0, '0, '0, el, ef, 0, 0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
